// File: rtl/fir_out_stage_pkg.sv
// fir_out_stage_pkg
// Shared FIR package: the control broadcast seen by every tile, the
// tile-to-tile bus, the psum/sample data bus and the output-stage state enum.
// No ports; imported by the FIR tile chain and by fir_out_stage.

package fir_out_stage_pkg;

    localparam int FIR_DATA_W  = 32;
    localparam int FIR_OUT_W   = 16;
    localparam int FIR_SHIFT_W = 5;
    localparam int FIR_MODE_W  = 2;
    localparam int FIR_NUM_W   = 16;

    typedef struct packed {
        logic                  valid;
        logic [FIR_DATA_W-1:0] data;
    } FIR_DATA_BUS;

    typedef struct packed {
        FIR_DATA_BUS sample;
        FIR_DATA_BUS psum;
    } FIR_TILE_TO_TILE;

    typedef struct packed {
        logic                   valid;
        logic                   flush;
        logic [FIR_MODE_W-1:0]  mode;
        logic [FIR_SHIFT_W-1:0] shift;
        logic [FIR_NUM_W-1:0]   num;
    } FIR_CONT_TO_TILE;

    typedef enum logic [1:0] {
        FIR_OUT_IDLE,
        FIR_OUT_WARMUP,
        FIR_OUT_RUN
    } FIR_OUT_STATE_E;

    // Number of leading psums that are still filling the tap line and must
    // be thrown away before the first valid output.
    function automatic logic [FIR_NUM_W-1:0] fir_warm_count(input logic [FIR_NUM_W-1:0] num);
        return (num == '0) ? '0 : num - FIR_NUM_W'(1);
    endfunction

endpackage

// File: rtl/fir_out_stage_if.sv
// fir_out_stage_if
// Valid/ready stream carrying the final signed output samples.
//   out_valid : sample available (driven by the master)
//   out_data  : signed sample, OUT_W bits (driven by the master)
//   out_ready : sink accepts the sample (driven by the slave)

interface fir_out_stage_if
    import fir_out_stage_pkg::*;
#(
    parameter int OUT_W = FIR_OUT_W
);

    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/fir_out_stage_fifo.sv
// fir_out_fifo
// Show-ahead FIFO: the head entry is visible whenever the FIFO is not empty.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the FIFO, wins over push and pop
//   push       : write push_data (push together with pop is legal when full)
//   pop        : drop the head entry (ignored when empty)
//   head_valid : FIFO not empty
//   head_data  : head entry, forced to zero while empty
//   count      : number of stored entries

module fir_out_fifo
    import fir_out_stage_pkg::*;
#(
    parameter int WIDTH = FIR_OUT_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A push into a full FIFO is only legal when the head leaves in the same
    // cycle, which frees the slot being written.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // The upstream credit scheme must guarantee that nothing is ever lost.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/fir_out_stage.sv
// fir_out_stage
// Output post-processing of the FIR chain: drops warm-up psums, rounds or
// truncates while right-shifting, saturates to OUT_W and buffers the result.
//   clk, rst_n     : clock, asynchronous active-low reset
//   cont_in        : control broadcast (valid, flush, mode, shift, num)
//   from_last_tile : last tile output, only psum.valid/psum.data are used
//   tile_ready     : back-pressure to the last tile (its next_ready)
//   out_if         : valid/ready output sample stream (master side)
//   sat_flag       : sticky, some sample was clamped since reset/flush
//   out_count      : samples delivered since reset/flush, wraps

module fir_out_stage
    import fir_out_stage_pkg::*;
#(
    parameter int ACC_W = FIR_DATA_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  FIR_CONT_TO_TILE       cont_in,
    input  FIR_TILE_TO_TILE       from_last_tile,
    output logic                  tile_ready,
    fir_out_stage_if.master       out_if,
    output logic                  sat_flag,
    output logic [CNT_W-1:0]      out_count
);

    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W  = FCNT_W + 2;

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    FIR_OUT_STATE_E           state_q;
    FIR_OUT_STATE_E           state_d;
    logic [FIR_NUM_W-1:0]     warm_q;
    logic [FIR_NUM_W-1:0]     warm_d;
    logic [FIR_NUM_W-1:0]     cfg_warm;
    logic [FIR_SHIFT_W-1:0]   shift_q;
    logic                     trunc_q;

    logic                     cfg_load;
    logic                     flush;
    logic                     take;
    logic                     take_run;

    logic [ACC_W-1:0]         psum_data;
    logic signed [ACC_W:0]    psum_ext;
    logic signed [ACC_W:0]    round_add;
    logic signed [ACC_W:0]    shifted;

    logic                     s1_valid;
    logic signed [ACC_W:0]    s1_data;
    logic                     sat_hi;
    logic                     sat_lo;
    logic [OUT_W-1:0]         clamped;
    logic                     s2_valid;
    logic [OUT_W-1:0]         s2_data;

    logic [FCNT_W-1:0]        fifo_count;
    logic [OCC_W-1:0]         occupancy;
    logic                     fifo_valid;
    logic [OUT_W-1:0]         fifo_data;
    logic                     pop;

    logic                     unused_inputs;

    assign unused_inputs = ^{from_last_tile.sample, cont_in.mode[FIR_MODE_W-1:1]};

    assign cfg_load  = cont_in.valid && !cont_in.flush;
    assign flush     = cont_in.valid && cont_in.flush;
    assign cfg_warm  = fir_warm_count(cont_in.num);
    assign psum_data = from_last_tile.psum.data;

    // Everything already in flight counts against the FIFO, so an accepted
    // psum always has a slot waiting when it reaches the write port.
    assign occupancy  = OCC_W'(fifo_count) + OCC_W'(s1_valid) + OCC_W'(s2_valid);
    assign tile_ready = (state_q == FIR_OUT_IDLE) || (occupancy < OCC_W'(DEPTH));

    // IDLE keeps tile_ready high only to drain the tile; those psums are dropped.
    assign take     = from_last_tile.psum.valid && tile_ready && (state_q != FIR_OUT_IDLE);
    assign take_run = take && (state_q == FIR_OUT_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            trunc_q <= 1'b0;
        end else if (cfg_load) begin
            shift_q <= cont_in.shift;
            trunc_q <= cont_in.mode[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIR_OUT_IDLE;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    // A psum arriving with a new config is judged by the current state; the
    // reloaded warm-up count only applies from the next cycle.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (flush) begin
            state_d = FIR_OUT_IDLE;
            warm_d  = '0;
        end else if (cfg_load) begin
            warm_d  = cfg_warm;
            state_d = (cfg_warm != '0) ? FIR_OUT_WARMUP : FIR_OUT_RUN;
        end else if (take && (state_q == FIR_OUT_WARMUP)) begin
            warm_d = warm_q - FIR_NUM_W'(1);
            if (warm_q == FIR_NUM_W'(1)) begin
                state_d = FIR_OUT_RUN;
            end
        end
    end

    // One extra bit of headroom keeps the rounding add from wrapping even
    // at the largest shift.
    always_comb begin
        psum_ext  = $signed({psum_data[ACC_W-1], psum_data});
        round_add = '0;
        if (!trunc_q && (shift_q != '0)) begin
            round_add = (ACC_W+1)'(1) << (shift_q - FIR_SHIFT_W'(1));
        end
        shifted = (psum_ext + round_add) >>> shift_q;
    end

    always_comb begin
        sat_hi  = (s1_data > SAT_MAX);
        sat_lo  = (s1_data < SAT_MIN);
        clamped = s1_data[OUT_W-1:0];
        if (sat_hi) begin
            clamped = SAT_MAX[OUT_W-1:0];
        end else if (sat_lo) begin
            clamped = SAT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            sat_flag <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            s1_valid <= take_run;
            if (take_run) begin
                s1_data <= shifted;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= clamped;
                if (sat_hi || sat_lo) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

    assign pop = fifo_valid && out_if.out_ready;

    fir_out_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (s2_valid),
        .push_data  (s2_data),
        .pop        (pop),
        .head_valid (fifo_valid),
        .head_data  (fifo_data),
        .count      (fifo_count)
    );

    assign out_if.out_valid = fifo_valid;
    assign out_if.out_data  = fifo_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (flush) begin
            out_count <= '0;
        end else if (pop) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fir_out_stage.sv
// tb_fir_out_stage
// Self-checking bench for fir_out_stage: directed scenarios plus randomized
// streams compared against a floor-division / clamp reference model.

module tb_fir_out_stage;
    import fir_out_stage_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    FIR_CONT_TO_TILE cont_in;
    FIR_TILE_TO_TILE from_last_tile;
    logic            tile_ready;
    logic            sat_flag;
    logic [15:0]     out_count;

    fir_out_stage_if #(.OUT_W(16)) out_if ();

    fir_out_stage #(
        .ACC_W (32),
        .OUT_W (16),
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cont_in        (cont_in),
        .from_last_tile (from_last_tile),
        .tile_ready     (tile_ready),
        .out_if         (out_if),
        .sat_flag       (sat_flag),
        .out_count      (out_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] tx_q[$];
    logic [31:0] acc_q[$];
    int          rx_q[$];
    int          ready_pct = 100;
    int          first_pop;
    int          last_pop;
    int          first_acc;

    // Reference: floor((p + half) / 2^sh), half = 2^(sh-1) only when rounding.
    function automatic longint scale(input logic [31:0] p, input int sh, input bit trunc);
        longint v;
        longint d;
        longint q;
        v = longint'(signed'(p));
        d = longint'(1) << sh;
        if (!trunc && sh > 0) v = v + d / 2;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    function automatic int clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic clear_q();
        tx_q.delete();
        acc_q.delete();
        rx_q.delete();
    endtask

    task automatic send_cfg(input int num, input int sh, input int md, input bit fl);
        @(negedge clk);
        from_last_tile.psum.valid = 1'b0;
        cont_in.valid = 1'b1;
        cont_in.flush = fl;
        cont_in.num   = 16'(num);
        cont_in.shift = 5'(sh);
        cont_in.mode  = 2'(md);
        @(negedge clk);
        cont_in.valid = 1'b0;
        cont_in.flush = 1'b0;
    endtask

    // Drives tx_q as a valid/ready source and records accepted psums and
    // delivered samples; with until_drained it stops once everything is out.
    task automatic stream(input int max_cycles, input bit until_drained, output bit timed_out);
        int quiet;
        quiet = 0;
        timed_out = until_drained;
        first_pop = -1;
        last_pop  = -1;
        first_acc = -1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            from_last_tile.psum.valid = (tx_q.size() != 0);
            from_last_tile.psum.data  = (tx_q.size() != 0) ? tx_q[0] : 32'h0;
            out_if.out_ready = (int'($urandom_range(99)) < ready_pct);
            #1;
            if (from_last_tile.psum.valid && tile_ready) begin
                acc_q.push_back(tx_q.pop_front());
                if (first_acc < 0) first_acc = c;
            end
            if (out_if.out_valid && out_if.out_ready) begin
                rx_q.push_back(int'(signed'(out_if.out_data)));
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            if (tx_q.size() == 0 && !out_if.out_valid) quiet++;
            else quiet = 0;
            if (until_drained && quiet >= 6) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cont_in = '0;
        from_last_tile = '0;
        out_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (tile_ready !== 1'b1) $display("[TB] FAIL reset_tile_ready: got %b want 1", tile_ready); else n_pass++;
        n_checks++; if (out_if.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_if.out_valid); else n_pass++;
        n_checks++; if (out_if.out_data !== 16'h0) $display("[TB] FAIL reset_out_data: got %h want 0", out_if.out_data); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("[TB] FAIL reset_sat_flag: got %b want 0", sat_flag); else n_pass++;
        n_checks++; if (out_count !== 16'd0) $display("[TB] FAIL reset_out_count: got %0d want 0", out_count); else n_pass++;
    endtask

    task automatic test_idle_drop();
        bit to;
        clear_q();
        tx_q = '{32'd5, 32'd6, 32'd7};
        ready_pct = 100;
        stream(60, 1'b1, to);
        n_checks++; if (to !== 1'b0) $display("[TB] FAIL idle_timeout: got %b want 0", to); else n_pass++;
        n_checks++; if (acc_q.size() != 3) $display("[TB] FAIL idle_drained: got %0d want 3", acc_q.size()); else n_pass++;
        n_checks++; if (rx_q.size() != 0) $display("[TB] FAIL idle_outputs: got %0d want 0", rx_q.size()); else n_pass++;
    endtask

    task automatic test_warmup();
        bit to;
        send_cfg(0, 0, 0, 1'b1);
        send_cfg(4, 4, 0, 1'b0);
        clear_q();
        tx_q = '{32'd100, 32'd200, 32'd300, 32'd24, 32'hFFFF_FFE8};
        ready_pct = 100;
        stream(100, 1'b1, to);
        n_checks++; if (to !== 1'b0) $display("[TB] FAIL warm_timeout: got %b want 0", to); else n_pass++;
        n_checks++; if (rx_q.size() != 2) $display("[TB] FAIL warm_count_out: got %0d want 2", rx_q.size()); else n_pass++;
        n_checks++; if (rx_q[0] != 2) $display("[TB] FAIL warm_sample0: got %0d want 2", rx_q[0]); else n_pass++;
        n_checks++; if (rx_q[1] != -1) $display("[TB] FAIL warm_sample1: got %0d want -1", rx_q[1]); else n_pass++;
        n_checks++; if (out_count !== 16'd2) $display("[TB] FAIL warm_out_count: got %0d want 2", out_count); else n_pass++;
    endtask

    task automatic test_saturate();
        bit to;
        send_cfg(0, 0, 0, 1'b1);
        send_cfg(1, 0, 0, 1'b0);
        n_checks++; if (sat_flag !== 1'b0) $display("[TB] FAIL sat_pre: got %b want 0", sat_flag); else n_pass++;
        clear_q();
        tx_q = '{32'h7FFF_FFFF, 32'h8000_0000};
        stream(100, 1'b1, to);
        n_checks++; if (rx_q[0] != 32767) $display("[TB] FAIL sat_pos: got %0d want 32767", rx_q[0]); else n_pass++;
        n_checks++; if (rx_q[1] != -32768) $display("[TB] FAIL sat_neg: got %0d want -32768", rx_q[1]); else n_pass++;
        n_checks++; if (sat_flag !== 1'b1) $display("[TB] FAIL sat_flag: got %b want 1", sat_flag); else n_pass++;
    endtask

    task automatic test_truncate();
        bit to;
        send_cfg(0, 0, 0, 1'b1);
        send_cfg(1, 4, 1, 1'b0);
        clear_q();
        tx_q = '{32'd31};
        stream(60, 1'b1, to);
        n_checks++; if (rx_q[0] != 1) $display("[TB] FAIL trunc_31: got %0d want 1", rx_q[0]); else n_pass++;
        send_cfg(1, 4, 0, 1'b0);
        clear_q();
        tx_q = '{32'd31};
        stream(60, 1'b1, to);
        n_checks++; if (rx_q[0] != 2) $display("[TB] FAIL round_31: got %0d want 2", rx_q[0]); else n_pass++;
        n_checks++; if (out_count !== 16'd2) $display("[TB] FAIL trunc_out_count: got %0d want 2", out_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit to;
        send_cfg(0, 0, 0, 1'b1);
        send_cfg(1, 0, 0, 1'b0);
        clear_q();
        for (int i = 0; i < 10; i++) tx_q.push_back(32'($urandom_range(1000)));
        ready_pct = 0;
        stream(20, 1'b0, to);
        n_checks++; if (acc_q.size() != 4) $display("[TB] FAIL bp_accepted: got %0d want 4", acc_q.size()); else n_pass++;
        n_checks++; if (tile_ready !== 1'b0) $display("[TB] FAIL bp_tile_ready: got %b want 0", tile_ready); else n_pass++;
        n_checks++; if (out_if.out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid: got %b want 1", out_if.out_valid); else n_pass++;
        ready_pct = 100;
        stream(200, 1'b1, to);
        n_checks++; if (to !== 1'b0) $display("[TB] FAIL bp_timeout: got %b want 0", to); else n_pass++;
        n_checks++; if (rx_q.size() != 10) $display("[TB] FAIL bp_outputs: got %0d want 10", rx_q.size()); else n_pass++;
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] != clamp16(scale(acc_q[i], 0, 1'b0)))
                $display("[TB] FAIL bp_order[%0d]: got %0d want %0d", i, rx_q[i], clamp16(scale(acc_q[i], 0, 1'b0)));
            else n_pass++;
        end
        n_checks++; if (last_pop - first_pop + 1 != 10) $display("[TB] FAIL bp_back_to_back: got span %0d want 10", last_pop - first_pop + 1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit to;
        send_cfg(0, 0, 0, 1'b1);
        send_cfg(1, 2, 0, 1'b0);
        clear_q();
        for (int i = 0; i < 8; i++) tx_q.push_back($urandom() >> $urandom_range(0, 16));
        ready_pct = 100;
        stream(100, 1'b1, to);
        n_checks++; if (rx_q.size() != 8) $display("[TB] FAIL b2b_outputs: got %0d want 8", rx_q.size()); else n_pass++;
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++) begin
            n_checks++;
            if (rx_q[i] != clamp16(scale(acc_q[i], 2, 1'b0)))
                $display("[TB] FAIL b2b_data[%0d]: got %0d want %0d", i, rx_q[i], clamp16(scale(acc_q[i], 2, 1'b0)));
            else n_pass++;
        end
        n_checks++; if (first_pop - first_acc != 3) $display("[TB] FAIL b2b_latency: got %0d want 3", first_pop - first_acc); else n_pass++;
        n_checks++; if (last_pop - first_pop + 1 != 8) $display("[TB] FAIL b2b_throughput: got span %0d want 8", last_pop - first_pop + 1); else n_pass++;
        n_checks++; if (out_count !== 16'd8) $display("[TB] FAIL b2b_out_count: got %0d want 8", out_count); else n_pass++;
    endtask

    task automatic test_random();
        bit          to;
        int          num;
        int          sh;
        int          md;
        int          exp_q[$];
        bit          exp_sat;
        longint      v;
        logic [31:0] d;
        for (int r = 0; r < 4; r++) begin
            num = int'($urandom_range(1, 4));
            sh  = int'($urandom_range(0, 12));
            md  = int'($urandom_range(0, 1));
            send_cfg(0, 0, 0, 1'b1);
            send_cfg(num, sh, md, 1'b0);
            clear_q();
            exp_q.delete();
            exp_sat = 1'b0;
            for (int i = 0; i < 12; i++) begin
                d = $urandom() >> $urandom_range(0, 24);
                if ($urandom_range(0, 1) == 1) d = -d;
                tx_q.push_back(d);
            end
            ready_pct = 60;
            stream(400, 1'b1, to);
            for (int i = num - 1; i < acc_q.size(); i++) begin
                v = scale(acc_q[i], sh, md[0]);
                if (v > 32767 || v < -32768) exp_sat = 1'b1;
                exp_q.push_back(clamp16(v));
            end
            n_checks++; if (to !== 1'b0) $display("[TB] FAIL rnd%0d_timeout: got %b want 0", r, to); else n_pass++;
            n_checks++; if (rx_q.size() != exp_q.size()) $display("[TB] FAIL rnd%0d_outputs: got %0d want %0d", r, rx_q.size(), exp_q.size()); else n_pass++;
            for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (rx_q[i] != exp_q[i]) $display("[TB] FAIL rnd%0d_data[%0d]: got %0d want %0d", r, i, rx_q[i], exp_q[i]);
                else n_pass++;
            end
            n_checks++; if (out_count !== 16'(exp_q.size())) $display("[TB] FAIL rnd%0d_out_count: got %0d want %0d", r, out_count, exp_q.size()); else n_pass++;
            n_checks++; if (sat_flag !== exp_sat) $display("[TB] FAIL rnd%0d_sat_flag: got %b want %b", r, sat_flag, exp_sat); else n_pass++;
        end
        ready_pct = 100;
    endtask

    task automatic test_flush();
        bit to;
        send_cfg(0, 0, 0, 1'b1);
        send_cfg(1, 0, 0, 1'b0);
        clear_q();
        tx_q = '{32'h7FFF_FFFF, 32'd5, 32'd6};
        ready_pct = 100;
        stream(100, 1'b1, to);
        n_checks++; if (out_count !== 16'd3) $display("[TB] FAIL flush_pre_count: got %0d want 3", out_count); else n_pass++;
        n_checks++; if (sat_flag !== 1'b1) $display("[TB] FAIL flush_pre_sat: got %b want 1", sat_flag); else n_pass++;
        clear_q();
        tx_q = '{32'd7, 32'd8, 32'd9};
        ready_pct = 0;
        stream(10, 1'b0, to);
        n_checks++; if (out_if.out_valid !== 1'b1) $display("[TB] FAIL flush_buffered: got %b want 1", out_if.out_valid); else n_pass++;
        send_cfg(0, 0, 0, 1'b1);
        n_checks++; if (out_if.out_valid !== 1'b0) $display("[TB] FAIL flush_out_valid: got %b want 0", out_if.out_valid); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("[TB] FAIL flush_sat_flag: got %b want 0", sat_flag); else n_pass++;
        n_checks++; if (out_count !== 16'd0) $display("[TB] FAIL flush_out_count: got %0d want 0", out_count); else n_pass++;
        n_checks++; if (tile_ready !== 1'b1) $display("[TB] FAIL flush_tile_ready: got %b want 1", tile_ready); else n_pass++;
        clear_q();
        tx_q = '{32'd11, 32'd12};
        ready_pct = 100;
        stream(60, 1'b1, to);
        n_checks++; if (rx_q.size() != 0) $display("[TB] FAIL flush_idle_drop: got %0d want 0", rx_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        send_cfg(0, 0, 0, 1'b1);
        send_cfg(1, 1, 0, 1'b0);
        clear_q();
        tx_q.push_back(32'h4000_0000);
        for (int i = 0; i < 10; i++) tx_q.push_back(32'($urandom_range(5000)));
        ready_pct = 50;
        stream(8, 1'b0, to);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_if.out_valid !== 1'b0) $display("[TB] FAIL rstmid_out_valid: got %b want 0", out_if.out_valid); else n_pass++;
        n_checks++; if (out_if.out_data !== 16'h0) $display("[TB] FAIL rstmid_out_data: got %h want 0", out_if.out_data); else n_pass++;
        n_checks++; if (tile_ready !== 1'b1) $display("[TB] FAIL rstmid_tile_ready: got %b want 1", tile_ready); else n_pass++;
        n_checks++; if (sat_flag !== 1'b0) $display("[TB] FAIL rstmid_sat_flag: got %b want 0", sat_flag); else n_pass++;
        n_checks++; if (out_count !== 16'd0) $display("[TB] FAIL rstmid_out_count: got %0d want 0", out_count); else n_pass++;
        @(negedge clk);
        clear_q();
        from_last_tile.psum.valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_cfg(1, 0, 0, 1'b0);
        tx_q = '{32'd1234};
        ready_pct = 100;
        stream(60, 1'b1, to);
        n_checks++; if (rx_q.size() != 1) $display("[TB] FAIL rstmid_outputs: got %0d want 1", rx_q.size()); else n_pass++;
        n_checks++; if (rx_q[0] != 1234) $display("[TB] FAIL rstmid_first: got %0d want 1234", rx_q[0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_drop();
        test_warmup();
        test_saturate();
        test_truncate();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_out_stage.md
# fir_out_stage

Output post-processing stage of the FIR datapath, directly downstream of the last FIR tile in the chain. It consumes the final partial sum from that tile through the tile-to-tile bus and drives the tile's `next_ready`. It discards warm-up outputs, applies the configured right shift with rounding, and saturates to the output width. Results are buffered in a small FIFO and presented on a valid/ready output port.

## Interface
Parameters:
- `ACC_W`, default 32: psum data width; must equal the data width of `FIR_DATA_BUS`.
- `OUT_W`, default 16: output sample width.
- `DEPTH`, default 4: output FIFO entries, at least 3.
- `CNT_W`, default 16: width of the output sample counter.

Ports:
- `clk`, input, 1: clock; the block uses one clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `cont_in`, input, `$bits(FIR_CONT_TO_TILE)`: same control broadcast the tile chain receives.
  - Fields used: `valid`, `flush`, `mode`, `shift`, `num`.
- `from_last_tile`, input, `$bits(FIR_TILE_TO_TILE)`: output of the last tile.
  - Only `psum.valid` and `psum.data` are used.
- `tile_ready`, output, 1: wired to `next_ready` of the last tile.
- `out_valid`, output, 1: output sample available.
- `out_data`, output, `OUT_W`: signed output sample.
- `out_ready`, input, 1: downstream accepts the sample.
- `sat_flag`, output, 1: sticky; set when any sample saturated.
- `out_count`, output, `CNT_W`: number of samples delivered; wraps.

## Operation
- **Config latch.** On `cont_in.valid && !cont_in.flush`, latch `shift`, `mode` and `num`.
  - `mode[0] = 1` selects truncation; `mode[0] = 0` selects round-half-up.
  - Load the warm-up count `warm = (num == 0) ? 0 : num - 1`.
- **Flush.** `cont_in.valid && cont_in.flush` clears:
  - both pipe stages, the FIFO, `warm`, `sat_flag` and `out_count`;
  - the state, which goes to IDLE.
  - Latched `shift` and `mode` are kept.
- **FSM.**
  - IDLE: no psum is accepted; `tile_ready` is 1 so the tile FIFO drains. Psums arriving in IDLE are dropped.
  - On config: go to WARMUP if `warm > 0`, otherwise to RUN.
  - WARMUP: each accepted psum decrements `warm` and is discarded. Go to RUN when the last one is discarded (`warm == 1`).
  - RUN: each accepted psum enters the pipe.
  - A new config while in WARMUP or RUN reloads `warm` and re-enters WARMUP or RUN, without flushing.
- **Accept.** A psum is accepted when `from_last_tile.psum.valid && tile_ready`.
- **Stage 1 (round/shift).**
  - Sign-extend to `ACC_W+1` bits.
  - If rounding and `shift > 0`, add `1 << (shift-1)`.
  - Arithmetic right shift by `shift`.
- **Stage 2 (saturate).**
  - Clamp to `[-2^(OUT_W-1), 2^(OUT_W-1)-1]` and set `sat_flag` when clamping.
  - Write the result into the FIFO.
- **Output FIFO.** Show-ahead: `out_valid = !empty` and `out_data` = head entry.
  - A pop occurs on `out_valid && out_ready`; `out_count` increments on each pop.

## Timing
- **Reset values:**
  - `tile_ready` = 1, `out_valid` = 0, `out_data` = 0, `sat_flag` = 0, `out_count` = 0;
  - state = IDLE, both pipe stages invalid.
- **Latency.** A psum accepted in cycle t is in stage 1 at t+1 and in stage 2 at t+2, and is written at the t+2 edge. `out_valid` rises at t+3 if the FIFO was empty.
- **Throughput.** One sample per cycle while `out_ready` is held at 1.
- **Credit rule.** `tile_ready = (fifo_count + s1_valid + s2_valid) < DEPTH`; it is forced to 1 in IDLE.
  - The FIFO must never overflow. A write when full is an assertion failure.
- **Simultaneous push and pop on a full FIFO:** both are allowed and the count is unchanged.
- **Flush priority.** Flush in the same cycle as an accept, push or pop takes priority. The next cycle shows `out_valid` = 0.
- **Config with a valid psum in the same cycle:** the psum is handled under the old state and the new `warm` takes effect the next cycle.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronous).

## Structure
- The following go in the shared FIR package:
  - `FIR_CONT_TO_TILE`, `FIR_TILE_TO_TILE` and `FIR_DATA_BUS`;
  - a new enum `FIR_OUT_STATE_E` (IDLE, WARMUP, RUN).
- One sub-module, `fir_out_fifo`: a show-ahead FIFO with `flush` and a `count` output. The FSM, round and saturate logic stay in this block.

## Test plan
- Config with `num=4`, `shift=4`, round, then psums 100, 200, 300, 24, −24 → only 2 and −1 are output (24+8=32>>4; −24+8=−16>>4); `out_count` = 2.
- `shift=0`, psum `0x7FFFFFFF` → `out_data` = `0x7FFF` and `sat_flag` = 1. Psum `0x80000000` → `0x8000`.
- Hold `out_ready` = 0 while the tile streams 10 psums → `tile_ready` falls after 4 are accepted and there is no overflow. Then release → 10 outputs in order, back-to-back.
- Flush while 3 samples are buffered → `out_valid` = 0 the next cycle; `sat_flag` = 0 and `out_count` = 0; FSM is IDLE.
- `mode[0]` = 1, `shift=4`, psum 31 → 1 (truncation); with `mode[0]` = 0 → 2.
- Assert `rst_n` low while streaming → outputs go to their reset values immediately, and the first post-reset config with `num=1` outputs its first psum.
